// File: rtl/z16_multiport_register_file.sv
// Z16 GPR file: NUM_RD combinational read ports, write ports A/B (B wins), clear sequence after reset.
// Build option Z16_RF_BYPASS_EN: reads in RUN forward same-cycle writes (B, then A, then stored value).
//
// state    | meaning
// ST_CLEAR | zeroing mem[clr_ptr] one register per cycle; writes ignored, reads return 0
// ST_RUN   | clear done, o_ready=1, reads and writes active
module z16_multiport_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_ready,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rs_data,
  input  logic [ADDR_W-1:0]          i_wa_addr,
  input  logic                       i_wa_wen,
  input  logic [DATA_W-1:0]          i_wa_data,
  input  logic [ADDR_W-1:0]          i_wb_addr,
  input  logic                       i_wb_wen,
  input  logic [DATA_W-1:0]          i_wb_data,
  output logic                       o_wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                run;
  logic                wa_ok;
  logic                wb_ok;
  logic                conflict;

  assign run     = (state_q == ST_RUN);
  assign o_ready = run;

  // Qualified writes: only in RUN, and never to a hardwired r0.
  assign wa_ok    = run && i_wa_wen && !((ZERO_REG != 0) && (i_wa_addr == '0));
  assign wb_ok    = run && i_wb_wen && !((ZERO_REG != 0) && (i_wb_addr == '0));
  assign conflict = wa_ok && wb_ok && (i_wa_addr == i_wb_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      o_wr_conflict <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      o_wr_conflict <= conflict;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Port B is written last so it overrides A on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (!run) begin
        mem[clr_ptr_q] <= '0;
      end else begin
        if (wa_ok) mem[i_wa_addr] <= i_wa_data;
        if (wb_ok) mem[i_wb_addr] <= i_wb_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = i_rs_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem[addr];
`ifdef Z16_RF_BYPASS_EN
      if (wa_ok && (i_wa_addr == addr)) val = i_wa_data;
      if (wb_ok && (i_wb_addr == addr)) val = i_wb_data;
`endif
      if (!run || ((ZERO_REG != 0) && (addr == '0))) val = '0;
    end

    assign o_rs_data[k*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_z16_multiport_register_file.sv
// Self-checking bench for z16_multiport_register_file (default parameters, 16 x 16-bit, 2 read ports).
// Expected read data is queued from a reference model when reads are driven and popped when sampled.
module tb_z16_multiport_register_file;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_ready;
  logic [7:0]  i_rs_addr = '0;
  logic [31:0] o_rs_data;
  logic [3:0]  i_wa_addr = '0;
  logic        i_wa_wen  = 1'b0;
  logic [15:0] i_wa_data = '0;
  logic [3:0]  i_wb_addr = '0;
  logic        i_wb_wen  = 1'b0;
  logic [15:0] i_wb_data = '0;
  logic        o_wr_conflict;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    int          port;
    logic [15:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [15:0] model[16];

  z16_multiport_register_file dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_ready       (o_ready),
    .i_rs_addr     (i_rs_addr),
    .o_rs_data     (o_rs_data),
    .i_wa_addr     (i_wa_addr),
    .i_wa_wen      (i_wa_wen),
    .i_wa_data     (i_wa_data),
    .i_wb_addr     (i_wb_addr),
    .i_wb_wen      (i_wb_wen),
    .i_wb_data     (i_wb_data),
    .o_wr_conflict (o_wr_conflict)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] a);
    return (a == 4'd0) ? 16'h0000 : model[a];
  endfunction

  task automatic sb_push(input string n, input int p, input logic [15:0] e);
    sb_t s;
    s.name = n;
    s.port = p;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  task automatic test_reset();
    sb_t         e;
    logic [15:0] got;
    int          n;
    i_rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", o_ready);
    else pass_cnt++;
    total_cnt++;
    if (o_wr_conflict !== 1'b0) $display("FAIL reset_conflict got=%b exp=0", o_wr_conflict);
    else pass_cnt++;
    i_rst = 1'b0;
    n = 0;
    while (!o_ready && n < 40) begin tick(); n++; end
    total_cnt++;
    if (n !== 16) $display("FAIL initial_clear_edges got=%0d exp=16", n);
    else pass_cnt++;
    model_clear();

    // Preload every register with FFFF (r0 is hardwired and stays 0).
    for (int i = 0; i < 8; i++) begin
      i_wa_addr = 4'(2*i);   i_wa_data = 16'hFFFF; i_wa_wen = 1'b1;
      i_wb_addr = 4'(2*i+1); i_wb_data = 16'hFFFF; i_wb_wen = 1'b1;
      tick();
      if (2*i != 0) model[2*i] = 16'hFFFF;
      model[2*i+1] = 16'hFFFF;
    end
    i_wa_wen = 1'b0;
    i_wb_wen = 1'b0;
    i_rs_addr = {4'd1, 4'd15};
    #1;
    sb_push("preload_r15", 0, model_rd(4'd15));
    sb_push("preload_r1", 1, model_rd(4'd1));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end

    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_rs_addr = {4'd9, 4'd15};
    n = 0;
    while (!o_ready && n < 40) begin
      #1;
      sb_push("clear_phase_rd0", 0, 16'h0000);
      sb_push("clear_phase_rd1", 1, 16'h0000);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        got = o_rs_data[e.port*16 +: 16];
        total_cnt++;
        if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
        else pass_cnt++;
      end
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 16) $display("FAIL preload_clear_edges got=%0d exp=16", n);
    else pass_cnt++;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      i_rs_addr = {4'(2*i+1), 4'(2*i)};
      #1;
      sb_push("cleared_even", 0, 16'h0000);
      sb_push("cleared_odd", 1, 16'h0000);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        got = o_rs_data[e.port*16 +: 16];
        total_cnt++;
        if (got !== e.exp) $display("FAIL %s reg=%0d got=%h exp=%h", e.name, 2*i+e.port, got, e.exp);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_basic_rw();
    sb_t         e;
    logic [15:0] got;
    i_wa_addr = 4'd5; i_wa_data = 16'h1234; i_wa_wen = 1'b1;
    tick();
    i_wa_wen = 1'b0;
    model[5] = 16'h1234;
    i_rs_addr = {4'd0, 4'd5};
    #1;
    sb_push("a_write_r5", 0, 16'h1234);
    i_wb_addr = 4'd5; i_wb_data = 16'hBEEF; i_wb_wen = 1'b1;
    tick();
    i_wb_wen = 1'b0;
    model[5] = 16'hBEEF;
    // First sample is pending from before the edge; recheck old value order by popping now.
    i_rs_addr = {4'd5, 4'd0};
    #1;
    sb_push("b_write_r5", 1, 16'hBEEF);
    // The first queued entry targets port 0 with address 5 before B's write; port 0 now reads r0.
    e = sbq.pop_front();
    total_cnt++;
    if (e.exp !== 16'h1234) $display("FAIL sb_order got=%h exp=1234", e.exp);
    else pass_cnt++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
    i_wa_addr = 4'd5; i_wa_data = 16'h0000; i_wa_wen = 1'b0;
    i_wb_addr = 4'd5; i_wb_data = 16'h0000; i_wb_wen = 1'b0;
    tick();
    i_rs_addr = {4'd5, 4'd5};
    #1;
    sb_push("no_wen_port0", 0, 16'hBEEF);
    sb_push("no_wen_port1", 1, 16'hBEEF);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    sb_t         e;
    logic [15:0] got;
    logic        exp_cf;
    logic [3:0]  r0a, r1a;
    for (int it = 0; it < 24; it++) begin
      i_wa_addr = 4'($urandom_range(0, 15)); i_wa_data = 16'($urandom); i_wa_wen = 1'($urandom_range(0, 1));
      i_wb_addr = 4'($urandom_range(0, 15)); i_wb_data = 16'($urandom); i_wb_wen = 1'($urandom_range(0, 1));
      if (it % 4 == 0) begin i_wb_addr = i_wa_addr; i_wa_wen = 1'b1; i_wb_wen = 1'b1; end
      exp_cf = i_wa_wen && i_wb_wen && (i_wa_addr == i_wb_addr) && (i_wa_addr != 4'd0);
      if (i_wa_wen && i_wa_addr != 4'd0) model[i_wa_addr] = i_wa_data;
      if (i_wb_wen && i_wb_addr != 4'd0) model[i_wb_addr] = i_wb_data;
      tick();
      i_wa_wen = 1'b0;
      i_wb_wen = 1'b0;
      total_cnt++;
      if (o_wr_conflict !== exp_cf) $display("FAIL rand_conflict it=%0d got=%b exp=%b", it, o_wr_conflict, exp_cf);
      else pass_cnt++;
      r0a = (it % 4 == 0) ? i_wa_addr : 4'($urandom_range(0, 15));
      r1a = 4'($urandom_range(0, 15));
      i_rs_addr = {r1a, r0a};
      #1;
      sb_push("rand_rd0", 0, model_rd(r0a));
      sb_push("rand_rd1", 1, model_rd(r1a));
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        got = o_rs_data[e.port*16 +: 16];
        total_cnt++;
        if (got !== e.exp) $display("FAIL %s it=%0d got=%h exp=%h", e.name, it, got, e.exp);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_conflict();
    sb_t         e;
    logic [15:0] got;
    i_wa_addr = 4'd3; i_wa_data = 16'h1111; i_wa_wen = 1'b1;
    i_wb_addr = 4'd3; i_wb_data = 16'h2222; i_wb_wen = 1'b1;
    tick();
    i_wa_wen = 1'b0;
    i_wb_wen = 1'b0;
    model[3] = 16'h2222;
    total_cnt++;
    if (o_wr_conflict !== 1'b1) $display("FAIL conflict_r3_flag got=%b exp=1", o_wr_conflict);
    else pass_cnt++;
    i_rs_addr = {4'd0, 4'd3};
    #1;
    sb_push("conflict_r3_b_wins", 0, 16'h2222);
    tick();
    total_cnt++;
    if (o_wr_conflict !== 1'b0) $display("FAIL conflict_one_cycle got=%b exp=0", o_wr_conflict);
    else pass_cnt++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
    i_wa_addr = 4'd0; i_wa_data = 16'h1111; i_wa_wen = 1'b1;
    i_wb_addr = 4'd0; i_wb_data = 16'h2222; i_wb_wen = 1'b1;
    tick();
    i_wa_wen = 1'b0;
    i_wb_wen = 1'b0;
    total_cnt++;
    if (o_wr_conflict !== 1'b0) $display("FAIL conflict_r0_flag got=%b exp=0", o_wr_conflict);
    else pass_cnt++;
    i_rs_addr = {4'd0, 4'd0};
    #1;
    sb_push("conflict_r0_rd0", 0, 16'h0000);
    sb_push("conflict_r0_rd1", 1, 16'h0000);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_bypass();
    sb_t         e;
    logic [15:0] got;
    i_wa_addr = 4'd7; i_wa_data = 16'hA5A5; i_wa_wen = 1'b1;
    i_wb_addr = 4'd6; i_wb_data = 16'h0202; i_wb_wen = 1'b1;
    i_rs_addr = {4'd6, 4'd7};
    #1;
`ifdef Z16_RF_BYPASS_EN
    sb_push("bypass_same_cycle_r7", 0, 16'hA5A5);
    sb_push("bypass_same_cycle_r6", 1, 16'h0202);
`else
    sb_push("nobypass_same_cycle_r7", 0, model_rd(4'd7));
    sb_push("nobypass_same_cycle_r6", 1, model_rd(4'd6));
`endif
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
    tick();
    model[7] = 16'hA5A5;
    model[6] = 16'h0202;
    // Both ports target r6 now; B must win in the forwarded value and in storage.
    i_wa_addr = 4'd6; i_wa_data = 16'h0101;
    i_wb_addr = 4'd6; i_wb_data = 16'h0303;
    #1;
`ifdef Z16_RF_BYPASS_EN
    sb_push("bypass_prio_r6", 1, 16'h0303);
`else
    sb_push("nobypass_prio_r6", 1, 16'h0202);
`endif
    sb_push("next_cycle_r7", 0, 16'hA5A5);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
    tick();
    i_wa_wen = 1'b0;
    i_wb_wen = 1'b0;
    model[6] = 16'h0303;
    #1;
    sb_push("stored_r6", 1, 16'h0303);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    sb_t         e;
    logic [15:0] got;
    int          n;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL mid_clear_ready got=%b exp=0", o_ready);
    else pass_cnt++;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n = 0;
    while (!o_ready && n < 40) begin tick(); n++; end
    total_cnt++;
    if (n !== 16) $display("FAIL restart_clear_edges got=%0d exp=16", n);
    else pass_cnt++;
    model_clear();
    i_wa_addr = 4'd2; i_wa_data = 16'h0042; i_wa_wen = 1'b1;
    tick();
    i_wa_wen = 1'b0;
    model[2] = 16'h0042;
    i_rs_addr = {4'd2, 4'd2};
    #1;
    sb_push("run_write_r2", 0, model_rd(4'd2));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
    i_rst = 1'b1;
    tick();
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL run_reset_ready_drop got=%b exp=0", o_ready);
    else pass_cnt++;
    i_rst = 1'b0;
    n = 0;
    while (!o_ready && n < 40) begin tick(); n++; end
    total_cnt++;
    if (n !== 16) $display("FAIL run_reset_clear_edges got=%0d exp=16", n);
    else pass_cnt++;
    model_clear();
    #1;
    sb_push("r2_after_reclear", 1, model_rd(4'd2));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear_writes();
    sb_t         e;
    logic [15:0] got;
    int          n;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    i_wa_addr = 4'd4; i_wa_data = 16'h5555; i_wa_wen = 1'b1;
    i_wb_addr = 4'd4; i_wb_data = 16'h6666; i_wb_wen = 1'b1;
    tick();
    i_wa_wen = 1'b0;
    i_wb_wen = 1'b0;
    total_cnt++;
    if (o_wr_conflict !== 1'b0) $display("FAIL clear_conflict got=%b exp=0", o_wr_conflict);
    else pass_cnt++;
    n = 0;
    while (!o_ready && n < 40) begin tick(); n++; end
    total_cnt++;
    if (n !== 5) $display("FAIL clear_remaining_edges got=%0d exp=5", n);
    else pass_cnt++;
    model_clear();
    i_rs_addr = {4'd4, 4'd4};
    #1;
    sb_push("clear_write_ignored_rd0", 0, model_rd(4'd4));
    sb_push("clear_write_ignored_rd1", 1, model_rd(4'd4));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = o_rs_data[e.port*16 +: 16];
      total_cnt++;
      if (got !== e.exp) $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_rw();
    test_conflict();
    test_bypass();
    test_random();
    test_reset_mid();
    test_clear_writes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
